obi_sram_bank_ctrl: RTL and testbench

OBI_SRAM_BANK_CTRL -- requirements
Module: obi_sram_bank_ctrl

---
 rtl/obi_sram_bank_ctrl.sv | 176 +++++++++++++++++
 tb/tb_obi_sram_bank_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_sram_bank_ctrl.sv
// OBI slave in front of a NumBankRows x NumBanksPerWord array of single-port SRAM macros.
// One wide OBI word maps onto one row of macros; responses come back in order through a
// 2-deep response FIFO with combinational fall-through when the FIFO is empty.
module obi_sram_bank_ctrl #(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 512,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned SramDataWidth = 64,
  parameter int unsigned SramNumWords  = 2048,
  parameter int unsigned NumBankRows   = 4
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_ni,
  input  logic                                                      req_i,
  output logic                                                      gnt_o,
  input  logic [AddrWidth-1:0]                                      addr_i,
  input  logic                                                      we_i,
  input  logic [DataWidth/8-1:0]                                    be_i,
  input  logic [DataWidth-1:0]                                      wdata_i,
  input  logic [IdWidth-1:0]                                        aid_i,
  output logic                                                      rvalid_o,
  input  logic                                                      rready_i,
  output logic [DataWidth-1:0]                                      rdata_o,
  output logic [IdWidth-1:0]                                        rid_o,
  output logic                                                      err_o,
  output logic [NumBankRows*(DataWidth/SramDataWidth)-1:0]          sram_req_o,
  output logic                                                      sram_we_o,
  output logic [$clog2(SramNumWords)-1:0]                           sram_addr_o,
  output logic [DataWidth-1:0]                                      sram_wdata_o,
  output logic [DataWidth/8-1:0]                                    sram_be_o,
  input  logic [NumBankRows*DataWidth-1:0]                          sram_rdata_i
);

  localparam int unsigned NumBanksPerWord   = DataWidth / SramDataWidth;
  localparam int unsigned BeWidth           = DataWidth / 8;
  localparam int unsigned SramAddrWidth     = $clog2(SramNumWords);
  localparam int unsigned SramMacroSelWidth = (NumBankRows > 1) ? $clog2(NumBankRows) : 1;
  localparam int unsigned Off               = $clog2(BeWidth);
  localparam int unsigned RowLsb            = Off + SramAddrWidth;
  localparam int unsigned HiLsb             = RowLsb + SramMacroSelWidth;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;
  } rsp_t;

  logic [SramMacroSelWidth-1:0] row;
  logic                         in_range;
  logic                         access;
  logic                         sram_access;
  logic                         unused_addr;

  // Response-side state for the access accepted in the previous cycle
  logic                         inflight_q;
  logic                         rsp_rd_q;
  logic                         rsp_err_q;
  logic [IdWidth-1:0]           rsp_id_q;
  logic [SramMacroSelWidth-1:0] row_q;

  // Response FIFO
  rsp_t       fifo_q [2];
  logic       wptr_q;
  logic       rptr_q;
  logic [1:0] cnt_q;
  logic       push;
  logic       pop;

  logic [DataWidth-1:0] rd_row;
  rsp_t                 cur_rsp;

  // Address decode: byte offset is ignored, bits above the row field flag an error
  assign row         = addr_i[RowLsb +: SramMacroSelWidth];
  assign in_range    = ~|addr_i[AddrWidth-1:HiLsb] && (32'(row) < NumBankRows);
  assign unused_addr = ^addr_i[Off-1:0];

  // Credit-based grant: at most two responses outstanding (in flight + queued)
  assign gnt_o       = rst_ni && ((2'({1'b0, inflight_q}) + cnt_q) < 2'd2);
  assign access      = req_i && gnt_o;
  assign sram_access = access && in_range;

  assign sram_we_o    = sram_access && we_i;
  assign sram_addr_o  = addr_i[Off +: SramAddrWidth];
  assign sram_wdata_o = wdata_i;
  assign sram_be_o    = be_i;

  // Enable every bank of the addressed row only
  always_comb begin
    sram_req_o = '0;
    for (int unsigned r = 0; r < NumBankRows; r++) begin
      if (sram_access && (row == SramMacroSelWidth'(r))) begin
        sram_req_o[r*NumBanksPerWord +: NumBanksPerWord] = '1;
      end
    end
  end

  // Select read data of the row latched at acceptance
  always_comb begin
    rd_row = '0;
    for (int unsigned r = 0; r < NumBankRows; r++) begin
      if (row_q == SramMacroSelWidth'(r)) begin
        rd_row = sram_rdata_i[r*DataWidth +: DataWidth];
      end
    end
  end

  // Response produced this cycle; all-zero when nothing is in flight
  always_comb begin
    cur_rsp.rdata = rsp_rd_q ? rd_row : '0;
    cur_rsp.rid   = rsp_id_q;
    cur_rsp.err   = rsp_err_q;
  end

  assign pop  = (cnt_q != 2'd0) && rready_i;
  assign push = inflight_q && ((cnt_q != 2'd0) || !rready_i);

  // Output mux: FIFO head if queued, otherwise fall-through of the current response
  always_comb begin
    if (cnt_q != 2'd0) begin
      rvalid_o = 1'b1;
      rdata_o  = fifo_q[rptr_q].rdata;
      rid_o    = fifo_q[rptr_q].rid;
      err_o    = fifo_q[rptr_q].err;
    end else begin
      rvalid_o = inflight_q;
      rdata_o  = cur_rsp.rdata;
      rid_o    = cur_rsp.rid;
      err_o    = cur_rsp.err;
    end
  end

  // Capture the accepted access and maintain FIFO pointers/count
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q <= 1'b0;
      rsp_rd_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_id_q   <= '0;
      row_q      <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      inflight_q <= access;
      rsp_rd_q   <= sram_access && !we_i;
      rsp_err_q  <= access && !in_range;
      rsp_id_q   <= access ? aid_i : '0;
      if (access) begin
        row_q <= row;
      end
      if (push) begin
        wptr_q <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr_q] <= cur_rsp;
    end
  end

  // The credit rule must never let the FIFO overflow
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (cnt_q == 2'd2)));

endmodule

// File: tb/tb_obi_sram_bank_ctrl.sv
// Randomized self-checking bench for obi_sram_bank_ctrl with an SRAM array model and a
// transaction-level reference (byte-addressable memory plus expected-response queue).
module tb_obi_sram_bank_ctrl;

  localparam int AW = 48;
  localparam int DW = 512;
  localparam int IW = 4;
  localparam int NB = 8;
  localparam int NR = 4;
  localparam int BW = DW / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req;
  logic             gnt;
  logic [AW-1:0]    addr;
  logic             we;
  logic [BW-1:0]    be;
  logic [DW-1:0]    wdata;
  logic [IW-1:0]    aid;
  logic             rvalid;
  logic             rready;
  logic [DW-1:0]    rdata;
  logic [IW-1:0]    rid;
  logic             err;
  logic [NR*NB-1:0] sram_req;
  logic             sram_we;
  logic [10:0]      sram_addr;
  logic [DW-1:0]    sram_wdata;
  logic [BW-1:0]    sram_be;
  logic [NR*DW-1:0] sram_rdata;

  always #5 clk = ~clk;

  obi_sram_bank_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .gnt_o       (gnt),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .aid_i       (aid),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .rdata_o     (rdata),
    .rid_o       (rid),
    .err_o       (err),
    .sram_req_o  (sram_req),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_be_o   (sram_be),
    .sram_rdata_i(sram_rdata)
  );

  function automatic logic [DW-1:0] init_word(int r, int w);
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) begin
      v[k*32 +: 32] = 32'hA500_0000 ^ 32'(r << 16) ^ 32'(w << 8) ^ 32'(k);
    end
    return v;
  endfunction

  // SRAM macro array: one-cycle read latency, per-byte write enables (words 0..7 modelled)
  logic [DW-1:0] sram_mem [NR][8];
  logic          sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int r = 0; r < NR; r++) begin
        for (int w = 0; w < 8; w++) begin
          sram_mem[r][w] <= init_word(r, w);
        end
      end
      sram_init <= 1'b1;
    end else begin
      for (int r = 0; r < NR; r++) begin
        for (int k = 0; k < NB; k++) begin
          if (sram_req[r*NB+k]) begin
            if (sram_we) begin
              for (int b = 0; b < 8; b++) begin
                if (sram_be[k*8+b]) begin
                  sram_mem[r][sram_addr[2:0]][k*64+b*8 +: 8] <= sram_wdata[k*64+b*8 +: 8];
                end
              end
            end else begin
              sram_rdata[(r*NB+k)*64 +: 64] <= sram_mem[r][sram_addr[2:0]][k*64 +: 64];
            end
          end
        end
      end
    end
  end

  // Reference model
  typedef struct {
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [NR][8];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            dut_grants = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [AW-1:0] mk_addr(int r, int w, logic oor);
    logic [AW-1:0] a;
    a = (48'(r) << 17) | (48'(w) << 6) | 48'($urandom_range(0, 63));
    if (oor) a = a | (48'(1) << $urandom_range(19, AW - 1));
    return a;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // One bus cycle: drive, then compare outputs against the model and update it
  task automatic cycle(input logic rq, input logic w, input logic [AW-1:0] a,
                       input logic [BW-1:0] b, input logic [DW-1:0] d,
                       input logic [IW-1:0] id, input logic rr, input logic rstn);
    exp_t          e;
    logic          gnt_exp;
    logic          acc;
    logic          oor;
    int            row;
    int            word;
    logic [31:0]   mask;
    @(negedge clk);
    req = rq; we = w; addr = a; be = b; wdata = d; aid = id; rready = rr; rst_n = rstn;
    #1;
    if (!rstn) begin
      check("gnt_in_reset", gnt, 0);
      check("sram_req_in_reset", sram_req, 0);
      exp_q.delete();
    end else begin
      gnt_exp = exp_q.size() < 2;
      check("gnt", gnt, gnt_exp);
      check("rvalid", rvalid, exp_q.size() != 0);
      if (rq && gnt) dut_grants++;
      if (exp_q.size() != 0 && rr) begin
        e = exp_q.pop_front();
        check("rdata", rdata, e.rdata);
        check("rid", rid, e.rid);
        check("err", err, e.err);
      end
      acc  = rq && gnt_exp;
      oor  = |a[AW-1:19];
      row  = int'(a[18:17]);
      word = int'(a[8:6]);
      mask = (acc && !oor) ? (32'hFF << (row * 8)) : 32'h0;
      check("sram_req", sram_req, mask);
      check("sram_we", sram_we, acc && !oor && w);
      if (acc && !oor) begin
        check("sram_addr", sram_addr, a[16:6]);
        check("sram_be", sram_be, b);
        check("sram_wdata", sram_wdata, d);
      end
      if (acc) begin
        e.rid = id;
        e.err = oor;
        e.rdata = '0;
        if (!oor && w) begin
          for (int i = 0; i < BW; i++) if (b[i]) ref_mem[row][word][i*8 +: 8] = d[i*8 +: 8];
        end else if (!oor) begin
          e.rdata = ref_mem[row][word];
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 1'b0, '0, '0, '0, '0, rr, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) idle(1'b1);
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  logic [DW-1:0] pat;
  int            g0;

  initial begin
    for (int r = 0; r < NR; r++) for (int w = 0; w < 8; w++) ref_mem[r][w] = init_word(r, w);
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; aid = '0; rready = 1'b1;

    // Reset and post-reset values
    cycle(1'b1, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    idle(1'b1);
    check("post_reset_rvalid", rvalid, 0);
    check("post_reset_gnt", gnt, 1);
    check("post_reset_err", err, 0);
    check("post_reset_rdata", rdata, 0);
    check("post_reset_rid", rid, 0);

    // Full write then read of row 1 word 1
    pat = rand_data();
    cycle(1'b1, 1'b1, 48'h20040, '1, pat, 4'd3, 1'b1, 1'b1);
    check("wr_row1_banks", sram_req, 32'h0000_FF00);
    cycle(1'b1, 1'b0, 48'h20040, '0, '0, 4'd3, 1'b1, 1'b1);
    check("rd_row1_banks", sram_req, 32'h0000_FF00);
    idle(1'b1);
    check("rd_back_pattern", rdata, pat);
    drain();

    // Backpressure: exactly two grants, then in-order drain
    g0 = dut_grants;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, mk_addr(i % 4, i, 1'b0), '0, '0, IW'(i + 5), 1'b0, 1'b1);
    check("grants_under_stall", 32'(dut_grants - g0), 2);
    drain();

    // Back-to-back reads to rows 0,3,2
    cycle(1'b1, 1'b0, mk_addr(0, 2, 1'b0), '0, '0, 4'd1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, mk_addr(3, 4, 1'b0), '0, '0, 4'd2, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, mk_addr(2, 6, 1'b0), '0, '0, 4'd4, 1'b1, 1'b1);
    drain();

    // Out-of-range access
    cycle(1'b1, 1'b0, 48'h80000, '0, '0, 4'd9, 1'b1, 1'b1);
    check("oor_no_sram_req", sram_req, 0);
    idle(1'b1);
    check("oor_err", err, 1);
    check("oor_rdata", rdata, 0);
    drain();

    // Partial write to bank 0 only, then read back
    cycle(1'b1, 1'b1, mk_addr(2, 3, 1'b0), 64'h0000_0000_0000_00FF, rand_data(), 4'd6, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, mk_addr(2, 3, 1'b0), '0, '0, 4'd7, 1'b1, 1'b1);
    drain();

    // Reset with responses queued and in flight: all dropped
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, mk_addr(1, i, 1'b0), '0, '0, IW'(i), 1'b0, 1'b1);
    cycle(1'b1, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    idle(1'b1);
    check("after_reset_rvalid", rvalid, 0);
    check("after_reset_gnt", gnt, 1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, 1'($urandom),
            mk_addr($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 9) == 0),
            {$urandom, $urandom}, rand_data(), IW'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) != 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
